// File: rtl/result_collector.sv
// ---------------------------------------------------------------------------
// result_collector
//
// Collects GF elements coming out of the last processor stage, packs them
// LSB-first into OUT_W-bit words (K = OUT_W/GF_BIT lanes per word) and queues
// completed words in a small output FIFO with a valid/ready interface.
// Only elements whose op code equals CAPTURE_OP are taken; a row is
// N_ELEM elements long and starts with in_start. The input side cannot be
// stalled, so a word that completes while the FIFO is full (and nothing is
// leaving it) is dropped and flagged.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid           element present on in_data
//   in_start           first element of a row (qualified by in_valid)
//   in_op              op code travelling with the element
//   in_data            element value
//   out_valid          FIFO head word valid
//   out_ready          consumer accepts the head word
//   out_data           packed word (zero while out_valid is low)
//   out_last           head word is the last word of its row
//   busy               a row is in progress or the FIFO holds words
//   overflow           sticky: a completed word was dropped (FIFO full)
//   seq_err            sticky: row framing violated
//   clr_flags          synchronous clear of overflow and seq_err
// ---------------------------------------------------------------------------
module result_collector #(
  parameter int GF_BIT      = 4,
  parameter int OP_CODE_LEN = 4,
  parameter int OUT_W       = 32,
  parameter int N_ELEM      = 64,
  parameter int CAPTURE_OP  = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_start,
  input  logic [OP_CODE_LEN-1:0] in_op,
  input  logic [GF_BIT-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   overflow,
  output logic                   seq_err,
  input  logic                   clr_flags
);

  localparam int K      = OUT_W / GF_BIT;
  localparam int LANE_W = $clog2(K + 1);
  localparam int ELEM_W = $clog2(N_ELEM + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [OP_CODE_LEN-1:0] CAP_OP = OP_CODE_LEN'(CAPTURE_OP);
  localparam logic [LANE_W-1:0]      K_L    = LANE_W'(K);
  localparam logic [ELEM_W-1:0]      N_L    = ELEM_W'(N_ELEM);
  localparam logic [CNT_W-1:0]       FULL_L = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, PACK} state_t;

  // Writes element e into lane idx of word w (lane 0 = LSBs).
  function automatic logic [OUT_W-1:0] insert_lane(
    input logic [OUT_W-1:0]  w,
    input logic [LANE_W-1:0] idx,
    input logic [GF_BIT-1:0] e
  );
    logic [OUT_W-1:0] r;
    r = w;
    for (int i = 0; i < K; i++) begin
      if (idx == LANE_W'(i)) r[i*GF_BIT +: GF_BIT] = e;
    end
    return r;
  endfunction

  state_t              state, state_nxt;
  logic [LANE_W-1:0]   lane_cnt, lane_nxt;
  logic [ELEM_W-1:0]   elem_cnt, elem_nxt;
  logic [OUT_W-1:0]    lanes, lanes_nxt;

  logic                accept;
  logic                take;
  logic                row_start;
  logic                seq_set;
  logic [LANE_W-1:0]   cur_lane, lane_inc;
  logic [ELEM_W-1:0]   cur_elem, elem_inc;

  logic                vld_p0;
  logic [OUT_W-1:0]    word_p0;
  logic                last_p0;

  logic                vld_p1;
  logic [OUT_W-1:0]    word_p1;
  logic                last_p1;

  logic [OUT_W-1:0]    mem_data [FIFO_DEPTH];
  logic                mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                pop, push, drop, full;

  assign accept = in_valid && (in_op == CAP_OP);

  // Stage p0: framing FSM and lane packing
  always_comb begin
    state_nxt = state;
    lane_nxt  = lane_cnt;
    elem_nxt  = elem_cnt;
    lanes_nxt = lanes;
    take      = 1'b0;
    row_start = 1'b0;
    seq_set   = 1'b0;
    cur_lane  = lane_cnt;
    cur_elem  = elem_cnt;
    lane_inc  = '0;
    elem_inc  = '0;
    vld_p0    = 1'b0;
    word_p0   = lanes;
    last_p0   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (in_start) begin
            take      = 1'b1;
            row_start = 1'b1;
          end else begin
            // Element outside a row: nothing to attach it to.
            seq_set = 1'b1;
          end
        end
      end
      PACK: begin
        if (accept) begin
          take = 1'b1;
          if (in_start) begin
            // Restart mid-row: the partial word is abandoned, the element
            // opens a fresh row in this same cycle.
            row_start = 1'b1;
            seq_set   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (take) begin
      if (row_start) begin
        cur_lane = '0;
        cur_elem = '0;
        word_p0  = '0;
      end
      word_p0  = insert_lane(word_p0, cur_lane, in_data);
      lane_inc = cur_lane + LANE_W'(1);
      elem_inc = cur_elem + ELEM_W'(1);
      last_p0  = (elem_inc == N_L);

      if ((lane_inc == K_L) || last_p0) begin
        vld_p0    = 1'b1;
        lanes_nxt = '0;
        lane_nxt  = '0;
      end else begin
        lanes_nxt = word_p0;
        lane_nxt  = lane_inc;
      end

      if (last_p0) begin
        state_nxt = IDLE;
        elem_nxt  = '0;
      end else begin
        state_nxt = PACK;
        elem_nxt  = elem_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lane_cnt <= '0;
      elem_cnt <= '0;
      lanes    <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state    <= state_nxt;
      lane_cnt <= lane_nxt;
      elem_cnt <= elem_nxt;
      lanes    <= lanes_nxt;
      vld_p1   <= vld_p0;
    end
  end

  // Stage p1: completed word waiting to enter the FIFO
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      word_p1 <= word_p0;
      last_p1 <= last_p0;
    end
  end

  // Output FIFO. A pop in the same cycle frees the slot a full FIFO needs.
  assign full      = (count == FULL_L);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = vld_p1 && (!full || pop);
  assign drop      = vld_p1 && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= word_p1;
      mem_last[wr_ptr] <= last_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);

      // A set event in the same cycle as a clear wins.
      if (drop)           overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;

      if (seq_set)        seq_err <= 1'b1;
      else if (clr_flags) seq_err <= 1'b0;
    end
  end

  // Head word is gated so stale memory never shows while the FIFO is empty.
  assign out_data = out_valid ? mem_data[rd_ptr] : '0;
  assign out_last = out_valid && mem_last[rd_ptr];
  assign busy     = (state == PACK) || out_valid;

endmodule
